instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fdt16_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/fetch_skid.sv | 34 +++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/fdt16_pkg.sv
// Shared types and widths for the 16-bit fetch datapath.
package fdt16_pkg;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] INSTR_NOP = 16'h0000;

    // IDLE: nothing in flight, skid empty
    // RUN : a read issued last cycle is returning this cycle
    // HELD: returned data parked in the skid while the pipe is stalled
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HELD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC/control inputs, instruction-memory port and IF/ID outputs.
interface instr_fetch_if;
    import fdt16_pkg::*;

    logic [PC_W-1:0]    pc_in;
    logic               stall;
    logic               branch;
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_valid;

    // Fetch unit side.
    modport master (
        input  pc_in, stall, branch, imem_rdata,
        output imem_en, imem_addr, if_instr, if_pc, if_valid
    );

    // Environment side: PC, pipeline control, memory and decode.
    modport slave (
        output pc_in, stall, branch, imem_rdata,
        input  imem_en, imem_addr, if_instr, if_pc, if_valid
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry holding register for a read that returns while the pipe is stalled.
module fetch_skid
    import fdt16_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  fetch_entry_t entry_i,
    output fetch_entry_t entry_o,
    output logic         full_o
);

    fetch_entry_t entry_q;
    logic         full_q;

    // Clear wins over load so a flush never leaves stale data parked.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '{instr: INSTR_NOP, pc: '0};
            full_q  <= 1'b0;
        end else if (clear_i) begin
            entry_q <= '{instr: INSTR_NOP, pc: '0};
            full_q  <= 1'b0;
        end else if (load_i) begin
            entry_q <= entry_i;
            full_q  <= 1'b1;
        end
    end

    assign entry_o = entry_q;
    assign full_o  = full_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues synchronous IMEM reads straight from the PC,
// pairs returning data with its address and presents it on the IF/ID register.
//
// state | meaning
// IDLE  | nothing in flight, skid empty
// RUN   | read issued last cycle, data on imem_rdata now
// HELD  | stalled with the returned read parked in the skid
module instr_fetch
    import fdt16_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_e       state_q, state_d;
    logic               rd_en;
    logic [PC_W-1:0]    req_pc_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic [PC_W-1:0]    if_pc_q;
    logic               if_valid_q;

    logic               skid_load, skid_clear, skid_full;
    logic               out_from_mem, out_from_skid, out_bubble;
    fetch_entry_t       skid_in, skid_out;

    // Address goes straight from the PC; no read while stalled, flushing or in reset.
    assign rd_en         = !bus.stall && !bus.branch && !reset;
    assign bus.imem_en   = rd_en;
    assign bus.imem_addr = bus.pc_in;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a branch always flushes back to IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.branch) begin
            state_d = FS_IDLE;
        end else begin
            unique case (state_q)
                FS_IDLE: if (rd_en) state_d = FS_RUN;
                FS_RUN: begin
                    if (bus.stall)  state_d = FS_HELD;
                    else if (rd_en) state_d = FS_RUN;
                    else            state_d = FS_IDLE;
                end
                FS_HELD: begin
                    if (!bus.stall) state_d = rd_en ? FS_RUN : FS_IDLE;
                end
                default: state_d = FS_IDLE;
            endcase
        end
    end

    // Output decode: where the IF/ID register loads from and what the skid does.
    always_comb begin
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        out_from_mem  = 1'b0;
        out_from_skid = 1'b0;
        out_bubble    = 1'b0;
        if (bus.branch) begin
            skid_clear = 1'b1;
            out_bubble = 1'b1;
        end else begin
            unique case (state_q)
                FS_IDLE: out_bubble = !bus.stall;
                FS_RUN: begin
                    if (bus.stall) skid_load    = 1'b1;
                    else           out_from_mem = 1'b1;
                end
                FS_HELD: begin
                    if (!bus.stall && skid_full) begin
                        out_from_skid = 1'b1;
                        skid_clear    = 1'b1;
                    end
                end
                default: out_bubble = 1'b1;
            endcase
        end
    end

    // Remember the address of the read in flight so the data can be tagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_q <= '0;
        end else if (rd_en) begin
            req_pc_q <= bus.pc_in;
        end
    end

    assign skid_in = '{instr: bus.imem_rdata, pc: req_pc_q};

    fetch_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .entry_i (skid_in),
        .entry_o (skid_out),
        .full_o  (skid_full)
    );

    // IF/ID register: holds under stall, bubbles to NOP/0 when nothing arrives.
    always_ff @(posedge clk) begin
        if (reset || out_bubble) begin
            if_instr_q <= INSTR_NOP;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else if (out_from_mem) begin
            if_instr_q <= bus.imem_rdata;
            if_pc_q    <= req_pc_q;
            if_valid_q <= 1'b1;
        end else if (out_from_skid) begin
            if_instr_q <= skid_out.instr;
            if_pc_q    <= skid_out.pc;
            if_valid_q <= 1'b1;
        end
    end

    assign bus.if_instr = if_instr_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.if_valid = if_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a PC model drives pc_in, a synchronous ROM answers reads,
// and a queue-based reference predicts the IF/ID outputs every cycle.
module tb_instr_fetch;
    import fdt16_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_fetch_if bus_if ();

    instr_fetch u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [15:0] rom [512];

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (bus_if.imem_en) bus_if.imem_rdata <= rom[bus_if.imem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: every issued address is queued; each unstalled edge delivers the
    // oldest one issued in an earlier cycle, or a bubble. Stall holds, flush empties.
    logic [8:0]  pc_q;
    logic        exp_valid;
    logic [8:0]  exp_pc;
    logic [15:0] exp_instr;
    int          pend_pc[$];
    int          pend_t[$];
    int          cyc;

    task automatic cycle(input logic r, input logic s, input logic b, input logic [8:0] tgt);
        reset         = r;
        bus_if.stall  = s;
        bus_if.branch = b;
        bus_if.pc_in  = pc_q;
        #4;
        check("imem_en",   bus_if.imem_en,   !(r || s || b));
        check("imem_addr", bus_if.imem_addr, pc_q);
        check("if_valid",  bus_if.if_valid,  exp_valid);
        check("if_pc",     bus_if.if_pc,     exp_pc);
        check("if_instr",  bus_if.if_instr,  exp_instr);
        @(posedge clk);
        if (r || b) begin
            pend_pc.delete();
            pend_t.delete();
            exp_valid = 1'b0;
            exp_pc    = '0;
            exp_instr = 16'h0000;
        end else if (!s) begin
            if (pend_t.size() > 0 && pend_t[0] < cyc) begin
                exp_pc    = 9'(pend_pc.pop_front());
                void'(pend_t.pop_front());
                exp_valid = 1'b1;
                exp_instr = rom[exp_pc];
            end else begin
                exp_valid = 1'b0;
                exp_pc    = '0;
                exp_instr = 16'h0000;
            end
            pend_pc.push_back(int'(pc_q));
            pend_t.push_back(cyc);
        end
        if (r)       pc_q = '0;
        else if (b)  pc_q = tgt;
        else if (!s) pc_q = pc_q + 9'd1;
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 16'hA000 + 16'(i);
        reset         = 1'b1;
        bus_if.stall  = 1'b0;
        bus_if.branch = 1'b0;
        bus_if.pc_in  = '0;
        pc_q      = '0;
        exp_valid = 1'b0;
        exp_pc    = '0;
        exp_instr = 16'h0000;
        cyc       = 0;
        @(posedge clk);
        #1;

        cycle(1'b1, 1'b0, 1'b0, 9'h000);
        cycle(1'b1, 1'b0, 1'b0, 9'h000);
        #4;
        check("rst_if_valid", bus_if.if_valid, 1'b0);
        check("rst_if_instr", bus_if.if_instr, 16'h0000);
        check("rst_if_pc",    bus_if.if_pc,    9'h000);
        check("rst_imem_en",  bus_if.imem_en,  1'b0);
        #6;

        // Streaming from pc 0, then a 3-cycle stall with pc 5 in flight.
        run(6);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 9'h000);
        run(4);

        // Taken branch to 0x023.
        cycle(1'b0, 1'b0, 1'b1, 9'h023);
        run(5);

        // Branch together with stall while the skid is full.
        run(3);
        cycle(1'b0, 1'b1, 1'b0, 9'h000);
        cycle(1'b0, 1'b1, 1'b0, 9'h000);
        cycle(1'b0, 1'b1, 1'b1, 9'h040);
        run(5);

        // Address wrap, then a reset pulse mid-stream.
        cycle(1'b0, 1'b0, 1'b1, 9'h1FE);
        run(5);
        cycle(1'b1, 1'b0, 1'b0, 9'h000);
        run(5);

        // Random mix of stalls, branches and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(logic'($urandom_range(0, 63) == 0),
                  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 7) == 0),
                  9'($urandom_range(0, 511)));
        end
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
